ysyx_23060208_axil_arbiter_n: RTL and testbench

Parametrised N-master to 1-slave AXI4-Lite arbiter connecting the IFU, EXU and future masters (DMA, debug) to one shared memory/peripheral port. It replaces the fixed two-master, done-signal-driven arbitration with independent round-robin read and write arbiters. Each arbiter holds its grant for one complete transaction, from address handshake to response handshake. All address, strobe and data widths are generic.

---
 rtl/ysyx_23060208_axil_arbiter_n_pkg.sv | 21 ++
 rtl/ysyx_23060208_rr_picker.sv | 34 +++
 rtl/ysyx_23060208_axil_arbiter_n.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_23060208_axil_arbiter_n.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_axil_arbiter_n_pkg.sv
// Shared definitions for the N-master AXI4-Lite arbiter: FSM encodings, response codes and
// the round-robin pointer advance helper.
package ysyx_23060208_axil_arbiter_n_pkg;

  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WReq, WResp} wr_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned MaxMasters = 8;

  // Index just after the one-hot owner, wrapping at n; the next search starts there.
  function automatic logic [2:0] next_ptr(input logic [MaxMasters-1:0] oh, input int unsigned n);
    next_ptr = '0;
    for (int unsigned i = 0; i < MaxMasters; i++) begin
      if (oh[i]) next_ptr = (i + 1 >= n) ? 3'd0 : 3'(i + 1);
    end
  endfunction

endpackage

// File: rtl/ysyx_23060208_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr_i.
module ysyx_23060208_rr_picker #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  localparam int unsigned PtrW = $clog2(N);
  localparam int unsigned SumW = PtrW + 1;

  logic [SumW-1:0] sum;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr_i < N and k < N, so a single subtraction is enough for the wrap.
      sum = {1'b0, ptr_i} + SumW'(k);
      if (sum >= SumW'(N)) sum = sum - SumW'(N);
      idx = sum[PtrW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060208_axil_arbiter_n.sv
// N-master to 1-slave AXI4-Lite arbiter with independent round-robin read and write arbiters,
// each holding its grant from address handshake to response handshake.
module ysyx_23060208_axil_arbiter_n
  import ysyx_23060208_axil_arbiter_n_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_araddr_i,
  input  logic [NUM_MASTERS-1:0]              m_arvalid_i,
  output logic [NUM_MASTERS-1:0]              m_arready_o,
  output logic [DATA_WIDTH-1:0]               m_rdata_o,
  output logic [1:0]                          m_rresp_o,
  output logic [NUM_MASTERS-1:0]              m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]              m_rready_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr_i,
  input  logic [NUM_MASTERS-1:0]              m_awvalid_i,
  output logic [NUM_MASTERS-1:0]              m_awready_o,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb_i,
  input  logic [NUM_MASTERS-1:0]              m_wvalid_i,
  output logic [NUM_MASTERS-1:0]              m_wready_o,
  output logic [1:0]                          m_bresp_o,
  output logic [NUM_MASTERS-1:0]              m_bvalid_o,
  input  logic [NUM_MASTERS-1:0]              m_bready_i,
  output logic [ADDR_WIDTH-1:0]               s_araddr_o,
  output logic                                s_arvalid_o,
  input  logic                                s_arready_i,
  input  logic [DATA_WIDTH-1:0]               s_rdata_i,
  input  logic [1:0]                          s_rresp_i,
  input  logic                                s_rvalid_i,
  output logic                                s_rready_o,
  output logic [ADDR_WIDTH-1:0]               s_awaddr_o,
  output logic                                s_awvalid_o,
  input  logic                                s_awready_i,
  output logic [DATA_WIDTH-1:0]               s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             s_wstrb_o,
  output logic                                s_wvalid_o,
  input  logic                                s_wready_i,
  input  logic [1:0]                          s_bresp_i,
  input  logic                                s_bvalid_i,
  output logic                                s_bready_o,
  output logic [NUM_MASTERS-1:0]              rd_grant_o,
  output logic [NUM_MASTERS-1:0]              wr_grant_o
);

  localparam int unsigned N     = NUM_MASTERS;
  localparam int unsigned PtrW  = $clog2(N);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  rd_state_e       rd_state_q, rd_state_d;
  wr_state_e       wr_state_q, wr_state_d;
  logic [N-1:0]    rd_gnt_q, rd_gnt_d, rd_pick;
  logic [N-1:0]    wr_gnt_q, wr_gnt_d, wr_pick;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;

  ysyx_23060208_rr_picker #(.N(N)) u_rd_picker (
    .req_i (m_arvalid_i),
    .ptr_i (rd_ptr_q),
    .gnt_o (rd_pick)
  );

  ysyx_23060208_rr_picker #(.N(N)) u_wr_picker (
    .req_i (m_awvalid_i | m_wvalid_i),
    .ptr_i (wr_ptr_q),
    .gnt_o (wr_pick)
  );

  logic in_raddr, in_rdata, in_wreq, in_wresp, aw_open, w_open, aw_hs, w_hs;

  assign in_raddr = (rd_state_q == RAddr);
  assign in_rdata = (rd_state_q == RData);
  assign in_wreq  = (wr_state_q == WReq);
  assign in_wresp = (wr_state_q == WResp);
  assign aw_open  = in_wreq & ~aw_done_q;
  assign w_open   = in_wreq & ~w_done_q;

  assign s_arvalid_o = in_raddr & |(rd_gnt_q & m_arvalid_i);
  assign m_arready_o = {N{in_raddr & s_arready_i}} & rd_gnt_q;
  assign s_rready_o  = in_rdata & |(rd_gnt_q & m_rready_i);
  assign m_rvalid_o  = {N{in_rdata & s_rvalid_i}} & rd_gnt_q;
  assign m_rdata_o   = in_rdata ? s_rdata_i : '0;
  assign m_rresp_o   = in_rdata ? s_rresp_i : RespOkay;

  assign s_awvalid_o = aw_open & |(wr_gnt_q & m_awvalid_i);
  assign m_awready_o = {N{aw_open & s_awready_i}} & wr_gnt_q;
  assign s_wvalid_o  = w_open & |(wr_gnt_q & m_wvalid_i);
  assign m_wready_o  = {N{w_open & s_wready_i}} & wr_gnt_q;
  assign s_bready_o  = in_wresp & |(wr_gnt_q & m_bready_i);
  assign m_bvalid_o  = {N{in_wresp & s_bvalid_i}} & wr_gnt_q;
  assign m_bresp_o   = in_wresp ? s_bresp_i : RespOkay;

  assign aw_hs = s_awvalid_o & s_awready_i;
  assign w_hs  = s_wvalid_o & s_wready_i;

  assign rd_grant_o = rd_gnt_q;
  assign wr_grant_o = wr_gnt_q;

  // One-hot grant muxes; grants are zero when idle, so the slave sees zero payload then.
  always_comb begin
    s_araddr_o = '0;
    s_awaddr_o = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_gnt_q[i]) s_araddr_o |= m_araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_gnt_q[i]) begin
        s_awaddr_o |= m_awaddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata_o  |= m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb_o  |= m_wstrb_i[i*StrbW +: StrbW];
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      RIdle: if (|m_arvalid_i) begin
        rd_gnt_d   = rd_pick;
        rd_state_d = RAddr;
      end
      RAddr: if (s_arvalid_o && s_arready_i) rd_state_d = RData;
      RData: if (s_rready_o && s_rvalid_i) begin
        rd_state_d = RIdle;
        rd_gnt_d   = '0;
        rd_ptr_d   = PtrW'(next_ptr(MaxMasters'(rd_gnt_q), N));
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      WIdle: if (|(m_awvalid_i | m_wvalid_i)) begin
        wr_gnt_d   = wr_pick;
        wr_state_d = WReq;
      end
      WReq: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) wr_state_d = WResp;
      end
      WResp: if (s_bready_o && s_bvalid_i) begin
        wr_state_d = WIdle;
        wr_gnt_d   = '0;
        wr_ptr_d   = PtrW'(next_ptr(MaxMasters'(wr_gnt_q), N));
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= RIdle;
      wr_state_q <= WIdle;
      rd_gnt_q   <= '0;
      wr_gnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_axil_arbiter_n.sv
// Directed bench for the N-master AXI4-Lite arbiter, three masters, slave driven by hand.
module tb_ysyx_23060208_axil_arbiter_n;
  import ysyx_23060208_axil_arbiter_n_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic [N-1:0]    m_wvalid, m_wready, m_bvalid, m_bready, rd_grant, wr_grant;
  logic [DW-1:0]   m_rdata, s_rdata, s_wdata;
  logic [1:0]      m_rresp, m_bresp, s_rresp, s_bresp;
  logic [AW-1:0]   s_araddr, s_awaddr;
  logic [SW-1:0]   s_wstrb;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready;

  ysyx_23060208_axil_arbiter_n #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .m_araddr_i  (m_araddr),
    .m_arvalid_i (m_arvalid),
    .m_arready_o (m_arready),
    .m_rdata_o   (m_rdata),
    .m_rresp_o   (m_rresp),
    .m_rvalid_o  (m_rvalid),
    .m_rready_i  (m_rready),
    .m_awaddr_i  (m_awaddr),
    .m_awvalid_i (m_awvalid),
    .m_awready_o (m_awready),
    .m_wdata_i   (m_wdata),
    .m_wstrb_i   (m_wstrb),
    .m_wvalid_i  (m_wvalid),
    .m_wready_o  (m_wready),
    .m_bresp_o   (m_bresp),
    .m_bvalid_o  (m_bvalid),
    .m_bready_i  (m_bready),
    .s_araddr_o  (s_araddr),
    .s_arvalid_o (s_arvalid),
    .s_arready_i (s_arready),
    .s_rdata_i   (s_rdata),
    .s_rresp_i   (s_rresp),
    .s_rvalid_i  (s_rvalid),
    .s_rready_o  (s_rready),
    .s_awaddr_o  (s_awaddr),
    .s_awvalid_o (s_awvalid),
    .s_awready_i (s_awready),
    .s_wdata_o   (s_wdata),
    .s_wstrb_o   (s_wstrb),
    .s_wvalid_o  (s_wvalid),
    .s_wready_i  (s_wready),
    .s_bresp_i   (s_bresp),
    .s_bvalid_i  (s_bvalid),
    .s_bready_o  (s_bready),
    .rd_grant_o  (rd_grant),
    .wr_grant_o  (wr_grant)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_araddr = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  logic [N-1:0] exp_g;

  initial begin
    clear_inputs();
    cyc();
    cyc();
    #1;
    check("reset_rd_grant", rd_grant, 0);
    check("reset_wr_grant", wr_grant, 0);
    check("reset_s_arvalid", s_arvalid, 0);
    check("reset_s_awvalid", s_awvalid, 0);
    rst_n = 1'b1;

    // Single read from master 1.
    cyc();
    m_arvalid = 3'b010;
    m_araddr[AW +: AW] = 32'h8000_0004;
    s_arready = 1'b1;
    #1;
    check("rd1_arvalid_same_cycle", s_arvalid, 0);
    check("rd1_grant_same_cycle", rd_grant, 0);
    cyc();
    #1;
    check("rd1_arvalid_next_cycle", s_arvalid, 1);
    check("rd1_araddr", s_araddr, 32'h8000_0004);
    check("rd1_grant", rd_grant, 3'b010);
    check("rd1_arready", m_arready, 3'b010);
    cyc();
    m_arvalid = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; m_rready = 3'b010;
    #1;
    check("rd1_rvalid_routed", m_rvalid, 3'b010);
    check("rd1_rdata", m_rdata, 32'hDEAD_BEEF);
    check("rd1_s_rready", s_rready, 1);
    check("rd1_grant_in_data", rd_grant, 3'b010);
    cyc();
    s_rvalid = 1'b0; s_rdata = '0; m_rready = '0;
    #1;
    check("rd1_idle_grant", rd_grant, 0);
    check("rd1_idle_rvalid", m_rvalid, 0);

    // Backpressure on master 2's read, then reset during the data phase.
    m_arvalid = 3'b100;
    m_araddr[2*AW +: AW] = 32'h3000_0000;
    s_arready = 1'b1;
    cyc();
    #1;
    check("bp_grant", rd_grant, 3'b100);
    cyc();
    m_arvalid = 3'b011; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678; m_rready = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_grant_held", rd_grant, 3'b100);
      check("bp_rdata_stable", m_rdata, 32'h1234_5678);
      check("bp_rvalid", m_rvalid, 3'b100);
      check("bp_no_rearb", s_arvalid, 0);
      cyc();
    end
    for (int i = 0; i < N; i++) m_araddr[i*AW +: AW] = 32'h1000 * (i + 1);
    m_arvalid = 3'b111; s_arready = 1'b1; m_rready = 3'b111;
    rst_n = 1'b0;
    #1;
    check("rst_rd_grant", rd_grant, 0);
    check("rst_rvalid", m_rvalid, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_s_rready", s_rready, 0);
    check("rst_s_arvalid", s_arvalid, 0);
    cyc();
    rst_n = 1'b1;

    // All three masters contend; order restarts at master 0 after reset.
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      cyc();
      #1;
      check("rr_grant", rd_grant, exp_g);
      check("rr_araddr", s_araddr, 32'h1000 * ((k % 3) + 1));
      cyc();
      #1;
      check("rr_rvalid", m_rvalid, exp_g);
      cyc();
      #1;
      check("rr_idle", rd_grant, 0);
    end
    clear_inputs();

    // Write from master 0 with w arriving three cycles after aw.
    cyc();
    m_awvalid = 3'b001;
    m_awaddr[0 +: AW] = 32'h2000_0010;
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    check("wr_awvalid_c1", s_awvalid, 0);
    cyc();
    #1;
    check("wr_awvalid_c2", s_awvalid, 1);
    check("wr_awaddr", s_awaddr, 32'h2000_0010);
    check("wr_grant", wr_grant, 3'b001);
    check("wr_wvalid_c2", s_wvalid, 0);
    check("wr_awready", m_awready, 3'b001);
    cyc();
    #1;
    check("wr_awvalid_gated_c3", s_awvalid, 0);
    check("wr_wvalid_c3", s_wvalid, 0);
    check("wr_awready_gated", m_awready, 0);
    cyc();
    m_wvalid = 3'b001;
    m_wdata[0 +: DW] = 32'hCAFE_F00D;
    m_wstrb[0 +: SW] = 4'b0011;
    #1;
    check("wr_wvalid_c4", s_wvalid, 1);
    check("wr_wstrb", s_wstrb, 4'b0011);
    check("wr_wdata", s_wdata, 32'hCAFE_F00D);
    check("wr_awvalid_c4", s_awvalid, 0);
    check("wr_wready", m_wready, 3'b001);
    cyc();
    m_awvalid = '0; m_wvalid = '0;
    s_bvalid = 1'b1; s_bresp = RespSlverr; m_bready = 3'b011;
    #1;
    check("wr_bvalid_routed", m_bvalid, 3'b001);
    check("wr_bresp", m_bresp, RespSlverr);
    check("wr_s_bready", s_bready, 1);
    check("wr_wvalid_resp", s_wvalid, 0);
    cyc();
    s_bvalid = 1'b0; m_bready = '0;
    #1;
    check("wr_idle_grant", wr_grant, 0);
    check("wr_idle_bvalid", m_bvalid, 0);

    // Master 0 writes while master 1 reads.
    m_awvalid = 3'b001; m_wvalid = 3'b001;
    m_awaddr[0 +: AW] = 32'h4000_0000;
    m_wdata[0 +: DW] = 32'h0BAD_F00D; m_wstrb[0 +: SW] = 4'b1111;
    m_arvalid = 3'b010; m_araddr[AW +: AW] = 32'h5000_0008;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    cyc();
    #1;
    check("cc_rd_grant", rd_grant, 3'b010);
    check("cc_wr_grant", wr_grant, 3'b001);
    check("cc_s_arvalid", s_arvalid, 1);
    check("cc_s_awvalid", s_awvalid, 1);
    check("cc_s_wvalid", s_wvalid, 1);
    check("cc_araddr", s_araddr, 32'h5000_0008);
    check("cc_awaddr", s_awaddr, 32'h4000_0000);
    cyc();
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; s_rresp = RespOkay; m_rready = 3'b010;
    s_bvalid = 1'b1; s_bresp = RespOkay; m_bready = 3'b001;
    #1;
    check("cc_rvalid", m_rvalid, 3'b010);
    check("cc_bvalid", m_bvalid, 3'b001);
    check("cc_rdata", m_rdata, 32'h5555_AAAA);
    check("cc_s_rready", s_rready, 1);
    check("cc_s_bready", s_bready, 1);
    cyc();
    clear_inputs();
    #1;
    check("cc_rd_idle", rd_grant, 0);
    check("cc_wr_idle", wr_grant, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
